// File: rtl/frame_tx_packer_pkg.sv
// Shared serial-transmit definitions: state encoding, frame-length width and
// the default frame sync word.
package frame_tx_packer_pkg;

  localparam int          TX_NUM_W      = 6;
  localparam logic [31:0] SYNC_WORD_DEF = 32'h55AA0701;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PAYLOAD,
    S_CSUM,
    S_WAIT_ACK
  } state_e;

endpackage

// File: rtl/frame_tx_packer_if.sv
// Request side and serialiser side of the frame packer.
// The packer holds the master modport; the requester/serialiser model holds the slave one.
interface frame_tx_packer_if
  import frame_tx_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 2
) ();

  logic                            frame_en_i;
  logic [NUM_WORDS*DATA_WIDTH-1:0] frame_data_i;
  logic                            tx_data_num_en_o;
  logic [TX_NUM_W-1:0]             tx_data_num_o;
  logic                            tx_valid_o;
  logic [DATA_WIDTH-1:0]           tx_data_o;
  logic                            tx_ack_i;
  logic                            busy_o;
  logic                            overrun_o;
  logic                            timeout_o;
  logic [15:0]                     drop_cnt_o;

  modport master (
    input  frame_en_i, frame_data_i, tx_ack_i,
    output tx_data_num_en_o, tx_data_num_o, tx_valid_o, tx_data_o,
           busy_o, overrun_o, timeout_o, drop_cnt_o
  );

  modport slave (
    output frame_en_i, frame_data_i, tx_ack_i,
    input  tx_data_num_en_o, tx_data_num_o, tx_valid_o, tx_data_o,
           busy_o, overrun_o, timeout_o, drop_cnt_o
  );

endinterface

// File: rtl/frame_tx_packer.sv
// Frame packer: emits SYNC_WORD, NUM_WORDS payload words and an optional running
// checksum back-to-back, then waits for the serialiser's frame-done ack.
module frame_tx_packer
  import frame_tx_packer_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_WORDS   = 2,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = DATA_WIDTH'(SYNC_WORD_DEF),
  parameter int                    CSUM_EN     = 1,
  parameter int                    PENDING_EN  = 1,
  parameter int                    ACK_TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  frame_tx_packer_if.master bus
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST    = IW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TMO_LIM = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam bit PEND = (PENDING_EN != 0);
  localparam bit CS   = (CSUM_EN != 0);
  localparam bit TMO  = (ACK_TIMEOUT > 0);

  if (NUM_WORDS < 1 || NUM_WORDS > 62) begin : g_bad_num_words
    $error("frame_tx_packer: NUM_WORDS must be in 1..62");
  end
  if (NUM_WORDS + CSUM_EN + 1 > 64) begin : g_bad_frame_len
    $error("frame_tx_packer: frame longer than 64 words");
  end

  typedef logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] frame_t;

  state_e                state;
  frame_t                fbuf, pbuf, launch_data;
  logic                  pending;
  logic [IW-1:0]         idx, nidx;
  logic [TW-1:0]         timer;
  logic [DATA_WIDTH-1:0] csum, tx_data;
  logic                  tx_valid, num_en, overrun, timeout;
  logic [15:0]           drop_cnt;

  logic busy_req, drop, latch, tmo_hit, finish, take_new, launch;

  // A request that coincides with the releasing ack still counts as "busy":
  // it either claims the free pending slot (and launches straight away) or is dropped.
  always_comb begin
    busy_req    = bus.frame_en_i && (state != S_IDLE);
    drop        = busy_req && (!PEND || pending);
    tmo_hit     = TMO && (state == S_WAIT_ACK) && !bus.tx_ack_i && (timer == TMO_LIM);
    finish      = (state == S_WAIT_ACK) && (bus.tx_ack_i || tmo_hit);
    latch       = busy_req && PEND && !pending && !finish;
    take_new    = bus.frame_en_i && PEND && !pending;
    launch      = (bus.frame_en_i && (state == S_IDLE)) || (finish && (pending || take_new));
    launch_data = pending ? pbuf : frame_t'(bus.frame_data_i);
    nidx        = idx + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      fbuf     <= '0;
      pbuf     <= '0;
      pending  <= 1'b0;
      idx      <= '0;
      timer    <= '0;
      csum     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      num_en   <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      num_en  <= 1'b0;
      overrun <= drop;
      timeout <= tmo_hit;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (latch) begin
        pending <= 1'b1;
        pbuf    <= frame_t'(bus.frame_data_i);
      end

      if (launch) begin
        state    <= S_SYNC;
        fbuf     <= launch_data;
        pending  <= 1'b0;
        tx_valid <= 1'b1;
        num_en   <= 1'b1;
        tx_data  <= SYNC_WORD;
      end else begin
        case (state)
          S_SYNC: begin
            state   <= S_PAYLOAD;
            idx     <= '0;
            tx_data <= fbuf[0];
            csum    <= fbuf[0];
          end
          S_PAYLOAD: begin
            if (idx == LAST) begin
              if (CS) begin
                state   <= S_CSUM;
                tx_data <= csum;
              end else begin
                state    <= S_WAIT_ACK;
                tx_valid <= 1'b0;
                timer    <= '0;
              end
            end else begin
              idx     <= nidx;
              tx_data <= fbuf[nidx];
              csum    <= csum + fbuf[nidx];
            end
          end
          S_CSUM: begin
            state    <= S_WAIT_ACK;
            tx_valid <= 1'b0;
            timer    <= '0;
          end
          S_WAIT_ACK: begin
            if (finish) state <= S_IDLE;
            else        timer <= timer + 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.tx_data_num_o    = TX_NUM_W'(NUM_WORDS + CSUM_EN);
  assign bus.tx_data_num_en_o = num_en;
  assign bus.tx_valid_o       = tx_valid;
  assign bus.tx_data_o        = tx_data;
  assign bus.busy_o           = (state != S_IDLE);
  assign bus.overrun_o        = overrun;
  assign bus.timeout_o        = timeout;
  assign bus.drop_cnt_o       = drop_cnt;

endmodule

// File: tb/tb_frame_tx_packer.sv
// Scoreboard bench: stimulus queues expected words with their cycle stamps,
// a negedge monitor pops and compares every presented word.
module tb_frame_tx_packer;
  import frame_tx_packer_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        num_en;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fen = 1'b0;
  logic [63:0] fdata = '0;
  logic        ack = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  int          t0;

  frame_tx_packer_if #(.DATA_WIDTH(32), .NUM_WORDS(2)) bus0 ();
  frame_tx_packer_if #(.DATA_WIDTH(32), .NUM_WORDS(2)) bus1 ();

  assign bus0.frame_en_i   = fen;
  assign bus0.frame_data_i = fdata;
  assign bus0.tx_ack_i     = ack;
  assign bus1.frame_en_i   = fen;
  assign bus1.frame_data_i = fdata;
  assign bus1.tx_ack_i     = ack;

  frame_tx_packer #(.ACK_TIMEOUT(8)) u0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  frame_tx_packer #(.ACK_TIMEOUT(8), .PENDING_EN(0)) u1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic push_frame(input int t, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] cs);
    sb.push_back('{t + 1, 32'h55AA0701, 1'b1});
    sb.push_back('{t + 2, w0, 1'b0});
    sb.push_back('{t + 3, w1, 1'b0});
    sb.push_back('{t + 4, cs, 1'b0});
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Monitor: every valid word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus0.tx_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected word: got %h want none (cycle %0d)", bus0.tx_data_o, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("word cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("word data", 64'(bus0.tx_data_o), 64'(mon_e.data));
        chk("word num_en", 64'(bus0.tx_data_num_en_o), 64'(mon_e.num_en));
      end
    end else if (bus0.tx_data_num_en_o === 1'b1) begin
      total++;
      bad++;
      $display("FAIL num_en without valid: got 1 want 0 (cycle %0d)", cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst valid", 64'(bus0.tx_valid_o), 64'd0);
    chk("rst num_en", 64'(bus0.tx_data_num_en_o), 64'd0);
    chk("rst data", 64'(bus0.tx_data_o), 64'd0);
    chk("rst busy", 64'(bus0.busy_o), 64'd0);
    chk("rst overrun", 64'(bus0.overrun_o), 64'd0);
    chk("rst timeout", 64'(bus0.timeout_o), 64'd0);
    chk("rst drop_cnt", 64'(bus0.drop_cnt_o), 64'd0);
    chk("data_num", 64'(bus0.tx_data_num_o), 64'd3);
    chk("u1 data_num", 64'(bus1.tx_data_num_o), 64'd3);
    rst = 1'b0;
    tick();

    // Basic frame
    t0 = cyc;
    fen = 1'b1; fdata = {32'h22222222, 32'h11111111};
    push_frame(t0, 32'h11111111, 32'h22222222, 32'h33333333);
    tick();
    fen = 1'b0;
    chk("basic busy", 64'(bus0.busy_o), 64'd1);
    wait_until(t0 + 5);
    chk("wait valid", 64'(bus0.tx_valid_o), 64'd0);
    chk("wait busy", 64'(bus0.busy_o), 64'd1);
    chk("wait hold data", 64'(bus0.tx_data_o), 64'h33333333);
    wait_until(t0 + 6);
    pulse_ack();
    chk("ack idle", 64'(bus0.busy_o), 64'd0);

    // Checksum wrap
    tick();
    t0 = cyc;
    fen = 1'b1; fdata = {32'h00000002, 32'hFFFFFFFF};
    push_frame(t0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001);
    tick();
    fen = 1'b0;
    wait_until(t0 + 6);
    pulse_ack();

    // Pending request relaunched on ack
    tick();
    t0 = cyc;
    fen = 1'b1; fdata = {32'h00000020, 32'h00000010};
    push_frame(t0, 32'h00000010, 32'h00000020, 32'h00000030);
    tick();
    fen = 1'b0;
    wait_until(t0 + 2);
    fen = 1'b1; fdata = {32'h00000B00, 32'h0000A000};
    tick();
    fen = 1'b0;
    chk("pend no overrun", 64'(bus0.overrun_o), 64'd0);
    wait_until(t0 + 10);
    push_frame(t0 + 10, 32'h0000A000, 32'h00000B00, 32'h0000AB00);
    pulse_ack();
    chk("pend busy", 64'(bus0.busy_o), 64'd1);
    chk("pend drop_cnt", 64'(bus0.drop_cnt_o), 64'd0);
    wait_until(t0 + 16);
    pulse_ack();
    chk("pend idle", 64'(bus0.busy_o), 64'd0);

    // Overrun: three requests in one busy period
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst2 drop_cnt", 64'(bus1.drop_cnt_o), 64'd0);
    t0 = cyc;
    fen = 1'b1; fdata = {32'h02020202, 32'h01010101};
    push_frame(t0, 32'h01010101, 32'h02020202, 32'h03030303);
    tick();
    fdata = {32'h20000000, 32'h10000000};
    tick();
    fdata = {32'hCAFEF00D, 32'hDEADBEEF};
    tick();
    fen = 1'b0;
    chk("ovr pulse", 64'(bus0.overrun_o), 64'd1);
    chk("ovr drop_cnt", 64'(bus0.drop_cnt_o), 64'd1);
    tick();
    chk("ovr pulse end", 64'(bus0.overrun_o), 64'd0);
    chk("ovr drop_cnt hold", 64'(bus0.drop_cnt_o), 64'd1);
    chk("nopend drop_cnt", 64'(bus1.drop_cnt_o), 64'd2);
    wait_until(t0 + 6);
    push_frame(t0 + 6, 32'h10000000, 32'h20000000, 32'h30000000);
    pulse_ack();
    wait_until(t0 + 12);
    pulse_ack();
    chk("ovr idle", 64'(bus0.busy_o), 64'd0);

    // Ack timeout
    tick();
    t0 = cyc;
    fen = 1'b1; fdata = {32'h80000000, 32'h80000000};
    push_frame(t0, 32'h80000000, 32'h80000000, 32'h00000000);
    tick();
    fen = 1'b0;
    wait_until(t0 + 12);
    chk("tmo early", 64'(bus0.timeout_o), 64'd0);
    chk("tmo early busy", 64'(bus0.busy_o), 64'd1);
    tick();
    chk("tmo pulse", 64'(bus0.timeout_o), 64'd1);
    chk("tmo idle", 64'(bus0.busy_o), 64'd0);
    tick();
    chk("tmo pulse end", 64'(bus0.timeout_o), 64'd0);

    // Reset in the middle of the payload
    t0 = cyc;
    fen = 1'b1; fdata = {32'h9ABCDEF0, 32'h12345678};
    sb.push_back('{t0 + 1, 32'h55AA0701, 1'b1});
    sb.push_back('{t0 + 2, 32'h12345678, 1'b0});
    tick();
    fen = 1'b0;
    wait_until(t0 + 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst valid", 64'(bus0.tx_valid_o), 64'd0);
    chk("midrst busy", 64'(bus0.busy_o), 64'd0);
    chk("midrst overrun", 64'(bus0.overrun_o), 64'd0);
    tick();
    t0 = cyc;
    fen = 1'b1; fdata = {32'h00000007, 32'h00000005};
    push_frame(t0, 32'h00000005, 32'h00000007, 32'h0000000C);
    tick();
    fen = 1'b0;
    wait_until(t0 + 6);
    pulse_ack();
    chk("clean idle", 64'(bus0.busy_o), 64'd0);

    repeat (3) tick();
    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_tx_packer.md
FRAME_TX_PACKER -- requirements
Module: frame_tx_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, serial word width.
REQ-002 SHALL have parameter NUM_WORDS, default 2, payload words per frame, range 1..62.
REQ-003 SHALL have parameter SYNC_WORD, default 32'h55AA0701, first word of every frame.
REQ-004 SHALL have parameter CSUM_EN, default 1; when 1, a checksum word is appended after the payload.
REQ-005 SHALL have parameter PENDING_EN, default 1; when 1, one request arriving while busy is queued.
REQ-006 SHALL have parameter ACK_TIMEOUT, default 1024, cycles to wait for tx_ack_i; 0 waits forever.
REQ-007 SHALL have one clock; reset is synchronous and active-high.
REQ-008 SHALL have port clk_i, input, 1, sole clock.
REQ-009 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-010 SHALL have port frame_en_i, input, 1, single-cycle frame request.
REQ-011 SHALL have port frame_data_i, input, NUM_WORDS*DATA_WIDTH, payload; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port tx_data_num_en_o, output, 1, frame-length strobe to the serialiser.
REQ-013 SHALL have port tx_data_num_o, output, 6, total frame words minus 1.
REQ-014 SHALL have port tx_valid_o, output, 1, word valid.
REQ-015 SHALL have port tx_data_o, output, DATA_WIDTH, word data.
REQ-016 SHALL have port tx_ack_i, input, 1, serialiser frame-done pulse.
REQ-017 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.
REQ-018 SHALL have port overrun_o, output, 1, one-cycle pulse when a request is dropped.
REQ-019 SHALL have port timeout_o, output, 1, one-cycle pulse when the ack wait expires.
REQ-020 SHALL have port drop_cnt_o, output, 16, saturating count of dropped requests.

Function
REQ-021 SHALL implement the states IDLE, SYNC, PAYLOAD, CSUM and WAIT_ACK.
REQ-022 SHALL sample frame_data_i into a frame buffer in the cycle frame_en_i is accepted.
REQ-023 SHALL, for a request accepted in IDLE at cycle T, drive tx_valid_o=1, tx_data_num_en_o=1 and tx_data_o=SYNC_WORD at T+1.
REQ-024 SHALL drive payload word k at T+2+k, with tx_valid_o high on consecutive cycles and no gaps.
REQ-025 SHALL, when CSUM_EN=1, drive at T+2+NUM_WORDS the modulo-2^DATA_WIDTH sum of the payload words, excluding SYNC_WORD.
REQ-026 SHALL drive tx_data_num_o constantly to NUM_WORDS+CSUM_EN.
REQ-027 SHALL drive tx_valid_o=0 and tx_data_num_en_o=0 outside SYNC, PAYLOAD and CSUM; tx_data_o holds its last value.
REQ-028 SHALL enter WAIT_ACK after the last word, and ignore tx_ack_i in any other state.
REQ-029 SHALL, on tx_ack_i in WAIT_ACK, go to SYNC next cycle if a request is pending, else to IDLE.
REQ-030 SHALL, when ACK_TIMEOUT>0, pulse timeout_o and leave WAIT_ACK as in REQ-029 once ACK_TIMEOUT cycles pass without tx_ack_i.
REQ-031 SHALL, with PENDING_EN=1, latch the first request and its data while busy; a request arriving while one is pending is dropped.
REQ-032 SHALL, with PENDING_EN=0, drop any request that arrives while busy.
REQ-033 SHALL, on every drop, pulse overrun_o and increment drop_cnt_o, saturating at 16'hFFFF.
REQ-034 SHALL treat frame_en_i coinciding with the accepting tx_ack_i as arriving while busy, so REQ-031/REQ-032 apply.
REQ-035 SHALL compute the checksum incrementally as words are issued, adding no extra latency.

Reset
REQ-036 SHALL, on rst_i, enter IDLE on the next edge and clear the pending flag, frame buffer, checksum and timeout counter.
REQ-037 SHALL reset every output to 0 (tx_data_num_o excepted, being constant); drop_cnt_o is 0.
REQ-038 SHALL, when reset is asserted mid-frame, abort the frame, send no further words and raise no ack or overrun pulse.

Structure
REQ-039 SHALL place the state encoding, the 6-bit tx_data_num width constant and the SYNC_WORD default in the shared serial package.
REQ-040 SHALL be a single module with no sub-module; it interfaces directly to the existing serial transmitter's num_en/num/valid/data/ack ports.
REQ-041 SHALL fail elaboration if NUM_WORDS+CSUM_EN+1 > 64.

Verification
REQ-042 Basic frame, defaults: data {32'h22222222, 32'h11111111}, with word 0 = 32'h11111111 -> words 55AA0701, 11111111, 22222222, 33333333 at T+1..T+4; num_en only at T+1; tx_data_num_o=3.
REQ-043 Checksum wrap: payload words FFFFFFFF and 00000002 -> checksum word 00000001.
REQ-044 Pending: second request at T+2 and ack at T+10 -> second SYNC at T+11, with no overrun.
REQ-045 Overrun: three requests during one busy period -> one frame queued, overrun_o pulses once, drop_cnt_o=1; with PENDING_EN=0 the same stimulus gives drop_cnt_o=2.
REQ-046 Timeout: ACK_TIMEOUT=8, no ack -> timeout_o pulses 8 cycles after WAIT_ACK entry, then the state returns to IDLE.
REQ-047 Reset mid-PAYLOAD: rst_i at T+2 -> tx_valid_o=0 from T+3 and busy_o=0; a request issued afterwards produces a clean frame.
